// File: rtl/vga_timing_if.sv
// Video timing output bundle: sync strobes, display enable and the pixel position they describe.
interface vga_timing_if;
   logic       hsync;
   logic       vsync;
   logic       de;
   logic [9:0] x;
   logic [9:0] y;
   logic       line_start;
   logic       frame_start;

   modport master (output hsync, vsync, de, x, y, line_start, frame_start);
   modport slave  (input  hsync, vsync, de, x, y, line_start, frame_start);
endinterface

// File: rtl/vga_timing.sv
// Raster timing generator: walks a (nx, ny) position counter one pixel per ce and
// registers the sync, enable and position outputs decoded from it.
module vga_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   vga_timing_if.master  vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Boundaries are 11 bits wide so a total of exactly 1024 still compares correctly.
   localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
   localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_VIS_END  = 11'(V_ACTIVE);
   localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic        SYNC_ON    = (SYNC_POL != 0);

   logic [9:0] nx;
   logic [9:0] ny;
   logic [10:0] nx_w;
   logic [10:0] ny_w;
   logic       h_vis;
   logic       v_vis;
   logic       h_pulse;
   logic       v_pulse;

   logic       hsync_q;
   logic       vsync_q;
   logic       de_q;
   logic [9:0] x_q;
   logic [9:0] y_q;
   logic       line_start_q;
   logic       frame_start_q;

   always_comb begin
      nx_w    = {1'b0, nx};
      ny_w    = {1'b0, ny};
      h_vis   = nx_w < H_VIS_END;
      v_vis   = ny_w < V_VIS_END;
      h_pulse = (nx_w >= H_SYNC_BEG) && (nx_w < H_SYNC_END);
      v_pulse = (ny_w >= V_SYNC_BEG) && (ny_w < V_SYNC_END);
   end

   // Outputs describe the position the counters held before this edge, so every
   // output is coherent with every other and none depends on an input combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         nx            <= '0;
         ny            <= '0;
         x_q           <= '0;
         y_q           <= '0;
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         hsync_q       <= ~SYNC_ON;
         vsync_q       <= ~SYNC_ON;
      end else if (ce) begin
         x_q           <= nx;
         y_q           <= ny;
         de_q          <= h_vis && v_vis;
         line_start_q  <= (nx == 10'd0);
         frame_start_q <= (nx == 10'd0) && (ny == 10'd0);
         hsync_q       <= h_pulse ? SYNC_ON : ~SYNC_ON;
         vsync_q       <= v_pulse ? SYNC_ON : ~SYNC_ON;
         if (nx == H_LAST) begin
            nx <= '0;
            ny <= (ny == V_LAST) ? 10'd0 : ny + 10'd1;
         end else begin
            nx <= nx + 10'd1;
         end
      end
   end

   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.de          = de_q;
   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: one default-timing instance plus two shrunken rasters
// (active-low and active-high sync) so whole frames fit in a short run.
module tb_vga_timing;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic [9:0] x;
      logic [9:0] y;
      logic       ls;
      logic       fs;
   } exp_t;

   localparam int HA[3]  = '{640, 16, 16};
   localparam int HF[3]  = '{16, 4, 4};
   localparam int HS[3]  = '{96, 6, 6};
   localparam int HB[3]  = '{48, 6, 6};
   localparam int VA[3]  = '{480, 12, 12};
   localparam int VF[3]  = '{10, 2, 2};
   localparam int VS[3]  = '{2, 2, 2};
   localparam int VB[3]  = '{33, 4, 4};
   localparam int POL[3] = '{0, 0, 1};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b0;

   vga_timing_if if0 ();
   vga_timing_if if1 ();
   vga_timing_if if2 ();

   vga_timing u0 (.clk(clk), .rst(rst), .ce(ce), .vga(if0));

   vga_timing #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_POL(0))
      u1 (.clk(clk), .rst(rst), .ce(ce), .vga(if1));

   vga_timing #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_POL(1))
      u2 (.clk(clk), .rst(rst), .ce(ce), .vga(if2));

   always #5 clk = ~clk;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   mnx[3];
   int   mny[3];
   exp_t mlast[3];
   exp_t sb_q0[$];
   exp_t sb_q1[$];
   exp_t sb_q2[$];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, observed, expected);
      end
   endtask

   function automatic exp_t decode(input int k, input int px, input int py);
      exp_t e;
      logic hp;
      logic vp;
      hp   = (px >= HA[k] + HF[k]) && (px < HA[k] + HF[k] + HS[k]);
      vp   = (py >= VA[k] + VF[k]) && (py < VA[k] + VF[k] + VS[k]);
      e.hs = (POL[k] != 0) ? hp : ~hp;
      e.vs = (POL[k] != 0) ? vp : ~vp;
      e.de = (px < HA[k]) && (py < VA[k]);
      e.x  = 10'(px);
      e.y  = 10'(py);
      e.ls = (px == 0);
      e.fs = (px == 0) && (py == 0);
      return e;
   endfunction

   function automatic exp_t observe(input int k);
      exp_t e;
      case (k)
         0:       e = '{if0.hsync, if0.vsync, if0.de, if0.x, if0.y, if0.line_start, if0.frame_start};
         1:       e = '{if1.hsync, if1.vsync, if1.de, if1.x, if1.y, if1.line_start, if1.frame_start};
         default: e = '{if2.hsync, if2.vsync, if2.de, if2.x, if2.y, if2.line_start, if2.frame_start};
      endcase
      return e;
   endfunction

   task automatic modelStep(input logic r, input logic c);
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            mnx[k]   = 0;
            mny[k]   = 0;
            mlast[k] = '{(POL[k] == 0), (POL[k] == 0), 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
         end else if (c) begin
            mlast[k] = decode(k, mnx[k], mny[k]);
            if (mnx[k] == HA[k] + HF[k] + HS[k] + HB[k] - 1) begin
               mnx[k] = 0;
               mny[k] = (mny[k] == VA[k] + VF[k] + VS[k] + VB[k] - 1) ? 0 : mny[k] + 1;
            end else begin
               mnx[k] = mnx[k] + 1;
            end
         end
      end
      sb_q0.push_back(mlast[0]);
      sb_q1.push_back(mlast[1]);
      sb_q2.push_back(mlast[2]);
   endtask

   // Drive on the falling edge, let the rising edge act, then score all three instances.
   task automatic applyStimulus(input logic r, input logic c);
      @(negedge clk);
      rst = r;
      ce  = c;
      modelStep(r, c);
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q0.size() == 0 || sb_q1.size() == 0 || sb_q2.size() == 0) begin
         checkOutput("sb_empty", 32'd0, 32'd1);
      end else begin
         checkOutput("u0_outputs", 32'(observe(0)), 32'(sb_q0.pop_front()));
         checkOutput("u1_outputs", 32'(observe(1)), 32'(sb_q1.pop_front()));
         checkOutput("u2_outputs", 32'(observe(2)), 32'(sb_q2.pop_front()));
      end
   endtask

   initial begin
      int hs_low;
      int ls_cnt;
      int vs1_low;
      int vs2_high;
      int fs_rise[$];
      int fs_width[$];
      int rise_at;
      logic prev_fs;
      logic found;

      hs_low   = 0;
      ls_cnt   = 0;
      vs1_low  = 0;
      vs2_high = 0;
      rise_at  = 0;

      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("rst_u0_x", 32'(if0.x), 32'd0);
      checkOutput("rst_u0_de", 32'(if0.de), 32'd0);
      checkOutput("rst_u0_hsync", 32'(if0.hsync), 32'd1);
      checkOutput("rst_u0_vsync", 32'(if0.vsync), 32'd1);
      checkOutput("rst_u2_hsync", 32'(if2.hsync), 32'd0);
      checkOutput("rst_u2_vsync", 32'(if2.vsync), 32'd0);

      for (int i = 0; i < 1700; i++) begin
         applyStimulus(1'b0, 1'b1);
         if (i == 0) begin
            checkOutput("first_xy", {if0.x, if0.y}, 32'd0);
            checkOutput("first_de", 32'(if0.de), 32'd1);
            checkOutput("first_fs", 32'(if0.frame_start), 32'd1);
            checkOutput("first_ls", 32'(if0.line_start), 32'd1);
         end
         if (i == 639) begin
            checkOutput("x639", 32'(if0.x), 32'd639);
            checkOutput("x639_de", 32'(if0.de), 32'd1);
            checkOutput("u1_last_xy", {if1.x, if1.y}, {10'd31, 10'd19});
         end
         if (i == 640) begin
            checkOutput("x640", 32'(if0.x), 32'd640);
            checkOutput("x640_de", 32'(if0.de), 32'd0);
            checkOutput("u1_wrap_xy", {if1.x, if1.y}, 32'd0);
         end
         if (i == 656) checkOutput("hsync_first_low", 32'(if0.hsync), 32'd0);
         if (i == 752) checkOutput("hsync_after_pulse", 32'(if0.hsync), 32'd1);
         if (i == 800) checkOutput("line_period", {if0.x, if0.y, if0.line_start}, {10'd0, 10'd1, 1'b1});
         if (i < 800) begin
            if (!if0.hsync) hs_low++;
            if (if0.line_start) ls_cnt++;
         end
         if (i < 640) begin
            if (!if1.vsync) vs1_low++;
            if (if2.vsync) vs2_high++;
         end
         if (if1.frame_start) fs_rise.push_back(i);
      end
      checkOutput("hsync_width", 32'(hs_low), 32'd96);
      checkOutput("line_start_count", 32'(ls_cnt), 32'd1);
      checkOutput("u1_vsync_width", 32'(vs1_low), 32'd64);
      checkOutput("u2_vsync_width", 32'(vs2_high), 32'd64);
      checkOutput("fs_pulses", 32'(fs_rise.size()), 32'd3);
      if (fs_rise.size() >= 2) checkOutput("frame_period", 32'(fs_rise[1] - fs_rise[0]), 32'd640);

      fs_rise.delete();
      prev_fs = if1.frame_start;
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(1'b0, (i % 2) == 0);
         if (if1.frame_start && !prev_fs) begin
            fs_rise.push_back(i);
            rise_at = i;
         end
         if (!if1.frame_start && prev_fs) fs_width.push_back(i - rise_at);
         prev_fs = if1.frame_start;
      end
      checkOutput("ce_fs_pulses", 32'(fs_rise.size() >= 2), 32'd1);
      if (fs_rise.size() >= 2) checkOutput("ce_frame_period", 32'(fs_rise[1] - fs_rise[0]), 32'd1280);
      checkOutput("ce_fs_widths", 32'(fs_width.size() >= 1), 32'd1);
      if (fs_width.size() >= 1) checkOutput("ce_fs_width", 32'(fs_width[0]), 32'd2);

      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         applyStimulus(1'b0, 1'b1);
         if (if1.x == 10'd22 && if1.y == 10'd15) found = 1'b1;
      end
      checkOutput("reach_sync_pos", 32'(found), 32'd1);
      checkOutput("mid_syncs_active", {if1.hsync, if1.vsync}, 32'd0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("midrst_u1", {if1.hsync, if1.vsync, if1.de, if1.x, if1.y}, {1'b1, 1'b1, 1'b0, 20'd0});
      checkOutput("midrst_u2_syncs", {if2.hsync, if2.vsync}, 32'd0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("restart_u1", {if1.x, if1.y, if1.de, if1.frame_start}, {20'd0, 1'b1, 1'b1});
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, meaning horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, meaning horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, meaning vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, meaning vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, meaning vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0, meaning sync polarity (0 = active-low, 1 = active-high).
REQ-010 SHALL have port clk, input, 1, the single clock; all flops on its rising edge.
REQ-011 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-012 SHALL have port ce, input, 1, pixel clock enable; one pixel per cycle with ce=1.
REQ-013 SHALL have port hsync, output, 1, horizontal sync at SYNC_POL polarity.
REQ-014 SHALL have port vsync, output, 1, vertical sync at SYNC_POL polarity.
REQ-015 SHALL have port de, output, 1, display enable: current pixel visible.
REQ-016 SHALL have port x, output, 10, current horizontal position.
REQ-017 SHALL have port y, output, 10, current vertical position.
REQ-018 SHALL have port line_start, output, 1, high while x==0.
REQ-019 SHALL have port frame_start, output, 1, high while x==0 and y==0.

Function
REQ-020 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525); both totals are at most 1024.
REQ-021 SHALL register all outputs; no output depends combinationally on any input.
REQ-022 SHALL hold an internal next-position counter pair (nx, ny); on each edge with ce=1 and rst=0, load outputs from the decode of (nx, ny), then advance the counters.
REQ-023 SHALL advance nx by 1 per ce; at nx==H_TOTAL-1, wrap nx to 0 and advance ny; at ny==V_TOTAL-1 with nx wrap, wrap ny to 0.
REQ-024 SHALL drive de=1 iff x<H_ACTIVE and y<V_ACTIVE.
REQ-025 SHALL assert hsync iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; defaults give x in 656..751.
REQ-026 SHALL assert vsync iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for the whole line; defaults give y in 490..491.
REQ-027 SHALL keep hsync, vsync, de, x, y, line_start and frame_start mutually coherent, all describing the same pixel in every cycle.
REQ-028 SHALL hold every output and counter unchanged on edges with ce=0; strobes stay high for the full ce period of their pixel.
REQ-029 SHALL invert asserted sync levels when SYNC_POL=1; inactive level is the complement.
REQ-030 SHALL never let x reach H_TOTAL or y reach V_TOTAL; there is no overflow state.

Reset
REQ-031 SHALL, on an edge with rst=1 (regardless of ce), set nx=0, ny=0, x=0, y=0, de=0, line_start=0, frame_start=0, and hsync and vsync to the inactive level (1 for SYNC_POL=0).
REQ-032 SHALL, on the first edge with rst=0 and ce=1 after reset, present x=0, y=0, de=1, line_start=1, frame_start=1.
REQ-033 SHALL abandon the frame when rst is asserted mid-frame and restart at (0,0) exactly as in REQ-032; no partial sync pulse continues.

Verification
REQ-034 Scenario: rst 3 cycles, ce=1 constant -> first post-reset cycle shows (0,0) with de=1 and frame_start=1; x=639 with de=1, then x=640 with de=0.
REQ-035 Scenario: ce=1 for one full line -> hsync low exactly for x=656..751 (96 cycles); line_start high at x=0 only; line period 800 cycles.
REQ-036 Scenario: ce=1 for two full frames -> frame_start pulses 420000 cycles apart; vsync low for y=490..491 (1600 cycles); y wraps 524->0 at x 799->0.
REQ-037 Scenario: ce toggling 1,0,1,0 -> outputs change only after ce=1 edges; frame period 840000 clk cycles; strobes 2 cycles wide.
REQ-038 Scenario: rst asserted at (700,491) during hsync/vsync -> next cycle: both syncs inactive, de=0, x=y=0; after release, behaviour matches REQ-034.
REQ-039 Scenario: SYNC_POL=1 -> hsync high for x=656..751, vsync high for y=490..491, both low during reset.
